ddr_round_ctrl: RTL

DDR_ROUND_CTRL -- requirements
Module: ddr_round_ctrl

---
 rtl/ddr_round_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ddr_round_ctrl.sv
// Rhythm-game round controller: one direction prompt per round, judged in the
// last quarter of a 16-step prompt; counts hits and misses until game over.
module ddr_round_ctrl #(
  parameter int unsigned MAX_MISSES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [1:0]  sw,
  input  logic        start,
  input  logic        up,
  input  logic        right,
  input  logic        left,
  input  logic        down,
  output logic [1:0]  dir,
  output logic        window_open,
  output logic [15:0] led,
  output logic [6:0]  score,
  output logic [1:0]  misses,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic        game_over
);

  typedef enum logic [1:0] {IDLE, PROMPT, JUDGE, GAMEOVER} state_t;

  state_t      state_q;
  logic [3:0]  lfsr_q, lfsr_d;
  logic [1:0]  dir_q;
  logic [3:0]  step_q;
  logic [1:0]  tcnt_q;
  logic [2:0]  step_len_q, step_len_d;
  logic [6:0]  score_q, score_d;
  logic [1:0]  misses_q;
  logic        hit_q, miss_q;
  logic        start_q, armed_q;
  logic [3:0]  btn_q;

  logic [3:0]  btn, btn_edge, dir_onehot;
  logic        start_edge, in_window, step_done, at_max, enter_prompt;

  // armed_q masks edges on the first clock after reset release, so a button
  // held through release is absorbed into the edge registers silently.
  always_comb begin
    btn        = {down, left, right, up};
    start_edge = armed_q & start & ~start_q;
    btn_edge   = {4{armed_q}} & btn & ~btn_q;
    lfsr_d     = {lfsr_q[2:0], ~(lfsr_q[3] ^ lfsr_q[2])};
    dir_onehot = 4'b0001 << dir_q;
    in_window  = (state_q == PROMPT) && (step_q >= 4'd12);
    step_done  = tick && ({1'b0, tcnt_q} == (step_len_q - 3'd1));
    at_max     = (misses_q == 2'(MAX_MISSES));
    score_d    = (score_q == 7'd99) ? '0 : score_q + 7'd1;
    case (sw)
      2'd0:    step_len_d = 3'd4;
      2'd1:    step_len_d = 3'd3;
      2'd2:    step_len_d = 3'd2;
      default: step_len_d = 3'd1;
    endcase
    enter_prompt = ((state_q == IDLE)     && start_edge) ||
                   ((state_q == JUDGE)    && !at_max)    ||
                   ((state_q == GAMEOVER) && start_edge);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      lfsr_q     <= '0;
      dir_q      <= '0;
      step_q     <= '0;
      tcnt_q     <= '0;
      step_len_q <= 3'd4;
      score_q    <= '0;
      misses_q   <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      start_q    <= 1'b0;
      btn_q      <= '0;
      armed_q    <= 1'b0;
    end else begin
      start_q <= start;
      btn_q   <= btn;
      armed_q <= 1'b1;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      case (state_q)
        PROMPT: begin
          // A judging edge wins over a coincident tick: no step advance.
          if (in_window && (|btn_edge)) begin
            state_q <= JUDGE;
            if (btn_edge == dir_onehot) begin
              score_q <= score_d;
              hit_q   <= 1'b1;
            end else begin
              misses_q <= misses_q + 2'd1;
              miss_q   <= 1'b1;
            end
          end else if (step_done) begin
            tcnt_q <= '0;
            if (step_q == 4'd15) begin
              state_q  <= JUDGE;
              misses_q <= misses_q + 2'd1;
              miss_q   <= 1'b1;
            end else begin
              step_q <= step_q + 4'd1;
            end
          end else if (tick) begin
            tcnt_q <= tcnt_q + 2'd1;
          end
        end
        JUDGE: begin
          if (at_max) state_q <= GAMEOVER;
        end
        GAMEOVER: begin
          if (start_edge) begin
            score_q  <= '0;
            misses_q <= '0;
          end
        end
        default: ;
      endcase
      if (enter_prompt) begin
        state_q    <= PROMPT;
        lfsr_q     <= lfsr_d;
        dir_q      <= lfsr_d[3:2];
        step_len_q <= step_len_d;
        step_q     <= '0;
        tcnt_q     <= '0;
      end
    end
  end

  always_comb begin
    case (state_q)
      PROMPT, JUDGE: led = 16'd1 << step_q;
      GAMEOVER:      led = '1;
      default:       led = '0;
    endcase
  end

  assign dir         = dir_q;
  assign window_open = in_window;
  assign score       = score_q;
  assign misses      = misses_q;
  assign hit_pulse   = hit_q;
  assign miss_pulse  = miss_q;
  assign game_over   = (state_q == GAMEOVER);

endmodule
